// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - client, control and VGA signal bundle for the frame scheduler
interface frame_scheduler_if;
  logic       run;
  logic       game_over;
  logic [8:0] g_x;
  logic [7:0] g_y;
  logic [2:0] g_colour;
  logic       g_plot;
  logic       g_done;
  logic [8:0] s_x;
  logic [7:0] s_y;
  logic [2:0] s_colour;
  logic       s_plot;
  logic       s_done;
  logic       new_frame;
  logic       erase;
  logic       g_start;
  logic       s_start;
  logic [2:0] speed;
  logic       new_level;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       overrun;
  logic [15:0] frame_count;

  // scheduler side
  modport slave (
    input  run, game_over,
    input  g_x, g_y, g_colour, g_plot, g_done,
    input  s_x, s_y, s_colour, s_plot, s_done,
    output new_frame, erase, g_start, s_start, speed, new_level,
    output vga_x, vga_y, vga_colour, vga_plot, overrun, frame_count
  );

  // game logic / draw clients / VGA side
  modport master (
    output run, game_over,
    output g_x, g_y, g_colour, g_plot, g_done,
    output s_x, s_y, s_colour, s_plot, s_done,
    input  new_frame, erase, g_start, s_start, speed, new_level,
    input  vga_x, vga_y, vga_colour, vga_plot, overrun, frame_count
  );
endinterface

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - frame tick divider, per-frame draw sequencer, VGA port arbiter and speed level
module frame_scheduler #(
  parameter int FRAME_DIV    = 833333,
  parameter int LEVEL_FRAMES = 1800
) (
  input logic              clock,
  input logic              resetn,
  frame_scheduler_if.slave bus
);

  localparam int DIV_W = $clog2(FRAME_DIV);
  localparam int LVL_W = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVEL_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ERASE, S_UPDATE, S_DRAW_G, S_DRAW_S, S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DIV_W-1:0] r_div;
  logic [LVL_W-1:0] r_level;
  logic [2:0]       r_speed;
  logic             r_s_start;
  logic             r_g_start;
  logic             r_overrun;
  logic [15:0]      r_frame_count;

  logic             w_tick;
  logic             w_level_wrap;
  logic             w_busy;
  logic             w_erase;
  logic             w_new_frame;
  logic             w_new_level;
  logic [8:0]       w_vga_x;
  logic [7:0]       w_vga_y;
  logic [2:0]       w_vga_colour;
  logic             w_vga_plot;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_level_wrap = (r_level == LVL_LAST);
  // a frame is in flight anywhere outside the resting states
  assign w_busy       = !(r_state == S_IDLE || r_state == S_WAIT || r_state == S_HALT);

  // free-running frame divider, unaffected by the FSM
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  // state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next-state logic; run/game_over are only looked at between frames
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.run) w_next = S_WAIT;
      S_WAIT: begin
        if (bus.game_over) w_next = S_HALT;
        else if (!bus.run) w_next = S_IDLE;
        else if (w_tick)   w_next = S_ERASE;
      end
      S_ERASE:  if (bus.s_done) w_next = S_UPDATE;
      S_UPDATE: w_next = S_DRAW_G;
      S_DRAW_G: if (bus.g_done) w_next = S_DRAW_S;
      S_DRAW_S: if (bus.s_done) w_next = S_WAIT;
      S_HALT:   if (!bus.run)   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // start pulses land on the first cycle of the pass they launch
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s_start <= 1'b0;
      r_g_start <= 1'b0;
    end else begin
      r_s_start <= (r_state == S_WAIT && w_next == S_ERASE) ||
                   (r_state == S_DRAW_G && w_next == S_DRAW_S);
      r_g_start <= (r_state == S_UPDATE);
    end
  end

  // level counter, speed, overrun flag and completed-frame counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_level       <= '0;
      r_speed       <= 3'd2;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (r_state == S_UPDATE) begin
        r_level <= w_level_wrap ? '0 : r_level + LVL_W'(1);
        if (w_level_wrap && r_speed != 3'd7) r_speed <= r_speed + 3'd1;
      end
      if (w_tick && w_busy) r_overrun <= 1'b1;
      if (r_state == S_DRAW_S && bus.s_done) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  // state-decoded outputs and the VGA port mux
  always_comb begin
    w_erase      = (r_state == S_ERASE);
    w_new_frame  = (r_state == S_UPDATE);
    w_new_level  = (r_state == S_UPDATE) && w_level_wrap && (r_speed != 3'd7);
    w_vga_x      = '0;
    w_vga_y      = '0;
    w_vga_colour = '0;
    w_vga_plot   = 1'b0;
    case (r_state)
      S_ERASE, S_DRAW_S: begin
        w_vga_x      = bus.s_x;
        w_vga_y      = bus.s_y;
        w_vga_colour = bus.s_colour;
        w_vga_plot   = bus.s_plot;
      end
      S_DRAW_G: begin
        w_vga_x      = bus.g_x;
        w_vga_y      = bus.g_y;
        w_vga_colour = bus.g_colour;
        w_vga_plot   = bus.g_plot;
      end
      default: ;
    endcase
  end

  assign bus.new_frame   = w_new_frame;
  assign bus.erase       = w_erase;
  assign bus.g_start     = r_g_start;
  assign bus.s_start     = r_s_start;
  assign bus.speed       = r_speed;
  assign bus.new_level   = w_new_level;
  assign bus.vga_x       = w_vga_x;
  assign bus.vga_y       = w_vga_y;
  assign bus.vga_colour  = w_vga_colour;
  assign bus.vga_plot    = w_vga_plot;
  assign bus.overrun     = r_overrun;
  assign bus.frame_count = r_frame_count;

endmodule
